// File: rtl/div_seq.sv
// Sequential restoring radix-2 divider for DIV/DIVU: one quotient bit per clock,
// fixed WIDTH+1 cycle latency, defined results for divide-by-zero and MIN / -1.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

    // Handshake: start is sampled only in IDLE (busy=0); busy rises the cycle
    // after acceptance and falls in the same cycle that done pulses for one cycle.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] quo_q, rem_q, bmag_q;
    logic [CNT_W-1:0] cnt_q;
    logic             qsign_q, rsign_q, dz_q, ov_q;
    logic             busy_q, done_q, div_zero_q, overflow_q;
    logic [WIDTH-1:0] q_q, r_q;

    // Operand capture: a zero divisor keeps the dividend raw so r comes out unmodified.
    logic             div_is_zero, a_neg_d, b_neg_d, ov_d;
    logic [WIDTH-1:0] amag_d, bmag_d;

    always_comb begin
        div_is_zero = (divisor == '0);
        a_neg_d     = is_signed & dividend[WIDTH-1] & ~div_is_zero;
        b_neg_d     = is_signed & divisor[WIDTH-1];
        amag_d      = a_neg_d ? (~dividend + 1'b1) : dividend;
        bmag_d      = b_neg_d ? (~divisor + 1'b1) : divisor;
        ov_d        = is_signed & (dividend == MIN_VAL) & (divisor == '1);
    end

    // One restoring step on {rem, quo}; the trial difference is WIDTH+1 bits wide.
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] rem_d, quo_d;

    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, bmag_q};
        if (diff[WIDTH]) begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            quo_q      <= '0;
            rem_q      <= '0;
            bmag_q     <= '0;
            cnt_q      <= '0;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            dz_q       <= 1'b0;
            ov_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        quo_q   <= amag_d;
                        rem_q   <= '0;
                        bmag_q  <= bmag_d;
                        cnt_q   <= '0;
                        qsign_q <= a_neg_d ^ b_neg_d;
                        rsign_q <= a_neg_d;
                        dz_q    <= div_is_zero;
                        ov_q    <= ov_d;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IT) state_q <= S_FIX;
                end
                S_FIX: begin
                    q_q        <= qsign_q ? (~quo_q + 1'b1) : quo_q;
                    r_q        <= rsign_q ? (~rem_q + 1'b1) : rem_q;
                    div_zero_q <= dz_q;
                    overflow_q <= ov_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign q         = q_q;
    assign r         = r_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule
